// File: rtl/tmr2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmr2_pkg
// Description : Shared types, reset constants and helper for the Timer2
//               peripheral (T2CON layout, default file addresses, prescale
//               ratio decode).
// Revision    : 1.0 - initial release
// ============================================================================
package tmr2_pkg;

   // Default file addresses on the external peripheral bus
   localparam logic [8:0] TMR2_ADDR_DFLT  = 9'h011;
   localparam logic [8:0] T2CON_ADDR_DFLT = 9'h012;
   localparam logic [8:0] PR2_ADDR_DFLT   = 9'h092;

   localparam logic [7:0] PR2_RST_VAL = 8'hFF;

   typedef enum logic [1:0] {
      CKPS_1_1     = 2'b00,
      CKPS_1_4     = 2'b01,
      CKPS_1_16    = 2'b10,
      CKPS_1_16_HI = 2'b11
   } ckps_e;

   // Implemented bits of T2CON; bit 7 is not stored and reads as zero.
   typedef struct packed {
      logic [3:0] toutps;
      logic       tmr2on;
      ckps_e      ckps;
   } t2con_t;

   // Terminal count of the 4-bit prescale counter for a given T2CKPS.
   function automatic logic [3:0] prescale_limit(input ckps_e ckps);
      case (ckps)
         CKPS_1_1: prescale_limit = 4'd0;
         CKPS_1_4: prescale_limit = 4'd3;
         default:  prescale_limit = 4'd15;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmr2_scaler.sv
`default_nettype none
// ============================================================================
// Module      : tmr2_scaler
// Description : 4-bit modulo counter used as the Timer2 prescaler and
//               postscaler. Counts enabled events 0..limit and flags the
//               event that lands on the terminal count.
// Ports       : clk, rst (async, active high), clr (sync clear, wins over
//               en), en (count event), limit[3:0] (terminal count),
//               wrap (combinational, high on the event that returns to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tmr2_scaler (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [3:0] limit,
   output logic       wrap
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Combinational so the owner acts on the same edge the count wraps.
   assign wrap = en & ~clr & (cnt_q == limit);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 4'd0;
      end else if (en) begin
         cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/tmr2_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tmr2_peripheral
// Description : Timer2 on the core's external peripheral bus. 8-bit timer
//               with prescaler, PR2 period match and postscaler. Owns TMR2,
//               T2CON and PR2 and requests PIR1.TMR2IF.
// Ports       : clk, rst (async, active high)
//               clkout          - clk/4 instruction-cycle strobe (sampled)
//               periph_addr     - file address
//               periph_data_in  - write data
//               periph_wr_en    - one-cycle write strobe
//               periph_data_out - read data, 8'h00 for foreign addresses
//               tmr2if_set_en   - one-cycle request to set TMR2IF
//               tmr2_match      - one-cycle pulse on each TMR2==PR2 reload
// Revision    : 1.0 - initial release
// ============================================================================
module tmr2_peripheral
   import tmr2_pkg::*;
#(
   parameter logic [8:0] ADDR_TMR2  = TMR2_ADDR_DFLT,
   parameter logic [8:0] ADDR_T2CON = T2CON_ADDR_DFLT,
   parameter logic [8:0] ADDR_PR2   = PR2_ADDR_DFLT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clkout,
   input  logic [8:0] periph_addr,
   input  logic [7:0] periph_data_in,
   input  logic       periph_wr_en,
   output logic [7:0] periph_data_out,
   output logic       tmr2if_set_en,
   output logic       tmr2_match
);

   logic       clkout_q;
   logic [7:0] tmr2_q,  tmr2_d;
   logic [7:0] pr2_q,   pr2_d;
   t2con_t     t2con_q, t2con_d;
   logic       match_q;
   logic       tmr2if_q;

   logic       tick;
   logic       wr_tmr2, wr_t2con, wr_pr2;
   logic       cnt_clr;
   logic       pre_en, pre_wrap;
   logic       tmr_match;
   logic       post_wrap;
   logic [3:0] pre_limit;

   assign tick     = clkout & ~clkout_q;
   assign wr_tmr2  = periph_wr_en & (periph_addr == ADDR_TMR2);
   assign wr_t2con = periph_wr_en & (periph_addr == ADDR_T2CON);
   assign wr_pr2   = periph_wr_en & (periph_addr == ADDR_PR2);

   // A TMR2/T2CON write restarts both scalers and swallows a coinciding tick.
   assign cnt_clr   = wr_tmr2 | wr_t2con;
   assign pre_en    = tick & t2con_q.tmr2on & ~cnt_clr;
   assign pre_limit = prescale_limit(t2con_q.ckps);

   // pr2_q is the pre-write value, so a same-cycle PR2 write compares old PR2.
   assign tmr_match = pre_wrap & (tmr2_q == pr2_q);

   tmr2_scaler u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (pre_en),
      .limit (pre_limit),
      .wrap  (pre_wrap)
   );

   tmr2_scaler u_postscaler (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (tmr_match),
      .limit (t2con_q.toutps),
      .wrap  (post_wrap)
   );

   always_comb begin
      tmr2_d  = tmr2_q;
      t2con_d = t2con_q;
      pr2_d   = pr2_q;
      if (wr_tmr2) begin
         tmr2_d = periph_data_in;
      end else if (pre_wrap) begin
         tmr2_d = tmr_match ? 8'h00 : tmr2_q + 8'd1;
      end
      if (wr_t2con) begin
         t2con_d = t2con_t'(periph_data_in[6:0]);
      end
      if (wr_pr2) begin
         pr2_d = periph_data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clkout_q <= 1'b0;
         tmr2_q   <= 8'h00;
         t2con_q  <= t2con_t'(7'h00);
         pr2_q    <= PR2_RST_VAL;
         match_q  <= 1'b0;
         tmr2if_q <= 1'b0;
      end else begin
         clkout_q <= clkout;
         tmr2_q   <= tmr2_d;
         t2con_q  <= t2con_d;
         pr2_q    <= pr2_d;
         match_q  <= tmr_match;
         tmr2if_q <= post_wrap;
      end
   end

   always_comb begin
      periph_data_out = 8'h00;
      if (periph_addr == ADDR_TMR2) begin
         periph_data_out = tmr2_q;
      end else if (periph_addr == ADDR_T2CON) begin
         periph_data_out = {1'b0, t2con_q};
      end else if (periph_addr == ADDR_PR2) begin
         periph_data_out = pr2_q;
      end
   end

   assign tmr2_match    = match_q;
   assign tmr2if_set_en = tmr2if_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr2_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmr2_peripheral
// Description : Self-checking bench for tmr2_peripheral. A cycle model of
//               the timer pushes the expected {TMR2, match, TMR2IF} for every
//               clock; the observed values are queued alongside and each
//               scenario task compares them, plus scenario-specific checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmr2_peripheral;

   localparam logic [8:0] A_TMR2  = 9'h011;
   localparam logic [8:0] A_T2CON = 9'h012;
   localparam logic [8:0] A_PR2   = 9'h092;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clkout = 1'b0;
   logic [8:0] periph_addr = 9'h000;
   logic [7:0] periph_data_in = 8'h00;
   logic       periph_wr_en = 1'b0;
   logic [7:0] periph_data_out;
   logic       tmr2if_set_en;
   logic       tmr2_match;

   always #10 clk = ~clk;

   tmr2_peripheral dut (
      .clk             (clk),
      .rst             (rst),
      .clkout          (clkout),
      .periph_addr     (periph_addr),
      .periph_data_in  (periph_data_in),
      .periph_wr_en    (periph_wr_en),
      .periph_data_out (periph_data_out),
      .tmr2if_set_en   (tmr2if_set_en),
      .tmr2_match      (tmr2_match)
   );

   int n_vec = 0;
   int n_err = 0;
   int ph    = 0;

   logic [9:0] exp_q[$];
   logic [9:0] act_q[$];

   // Reference model state
   logic [7:0] m_tmr;
   logic [7:0] m_pr2;
   logic [6:0] m_t2con;
   int         m_pre;
   int         m_post;
   logic       m_match;
   logic       m_if;
   logic       m_ck_q;

   task automatic model_reset();
      m_tmr = 8'h00; m_pr2 = 8'hFF; m_t2con = 7'h00;
      m_pre = 0; m_post = 0; m_match = 1'b0; m_if = 1'b0; m_ck_q = 1'b0;
   endtask

   // Prescaler counts ticks 1..ratio; postscaler counts matches 1..TOUTPS+1.
   task automatic model_step(input logic wr, input logic [8:0] a, input logic [7:0] d);
      logic       tick;
      logic [7:0] pr_old;
      int         ratio;
      tick    = clkout & ~m_ck_q;
      m_ck_q  = clkout;
      pr_old  = m_pr2;
      m_match = 1'b0;
      m_if    = 1'b0;
      if (wr && a == A_TMR2) begin
         m_tmr = d; m_pre = 0; m_post = 0;
      end else if (wr && a == A_T2CON) begin
         m_t2con = d[6:0]; m_pre = 0; m_post = 0;
      end else if (tick && m_t2con[2]) begin
         ratio = (m_t2con[1:0] == 2'd0) ? 1 : (m_t2con[1:0] == 2'd1) ? 4 : 16;
         m_pre = m_pre + 1;
         if (m_pre == ratio) begin
            m_pre = 0;
            if (m_tmr == pr_old) begin
               m_tmr   = 8'h00;
               m_match = 1'b1;
               m_post  = m_post + 1;
               if (m_post == int'(m_t2con[6:3]) + 1) begin
                  m_post = 0;
                  m_if   = 1'b1;
               end
            end else begin
               m_tmr = m_tmr + 8'd1;
            end
         end
      end
      if (wr && a == A_PR2) m_pr2 = d;
   endtask

   // One clock: drive at negedge, observe TMR2 readback and pulses after posedge.
   task automatic cyc(input logic wr, input logic [8:0] a, input logic [7:0] d);
      @(negedge clk);
      ph             = (ph + 1) % 4;
      clkout         = (ph >= 2);
      periph_wr_en   = wr;
      periph_addr    = a;
      periph_data_in = d;
      model_step(wr, a, d);
      exp_q.push_back({m_tmr, m_match, m_if});
      @(posedge clk);
      #1;
      periph_wr_en = 1'b0;
      periph_addr  = A_TMR2;
      #1;
      act_q.push_back({periph_data_out, tmr2_match, tmr2if_set_en});
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      periph_addr = A_TMR2; #1;
      n_vec++; if (periph_data_out !== 8'h00) begin n_err++; $display("FAIL reset_tmr2: got %h want 00", periph_data_out); end
      periph_addr = A_T2CON; #1;
      n_vec++; if (periph_data_out !== 8'h00) begin n_err++; $display("FAIL reset_t2con: got %h want 00", periph_data_out); end
      periph_addr = A_PR2; #1;
      n_vec++; if (periph_data_out !== 8'hFF) begin n_err++; $display("FAIL reset_pr2: got %h want FF", periph_data_out); end
      periph_addr = 9'h005; #1;
      n_vec++; if (periph_data_out !== 8'h00) begin n_err++; $display("FAIL reset_unowned: got %h want 00", periph_data_out); end
      n_vec++; if ({tmr2_match, tmr2if_set_en} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {tmr2_match, tmr2if_set_en}); end
   endtask

   task automatic test_periodic();
      logic [9:0] e, a;
      int last_m = -1, last_i = -1, nm = 0;
      cyc(1'b1, A_PR2, 8'h03);
      cyc(1'b1, A_T2CON, 8'h04);
      for (int i = 0; i < 80; i++) begin
         cyc(1'b0, A_TMR2, 8'h00);
         a = act_q[$];
         if (a[1]) begin
            if (last_m >= 0) begin
               n_vec++; if (i - last_m != 16) begin n_err++; $display("FAIL periodic_match_gap: got %0d want 16", i - last_m); end
            end
            last_m = i; nm++;
         end
         if (a[0]) begin
            if (last_i >= 0) begin
               n_vec++; if (i - last_i != 16) begin n_err++; $display("FAIL periodic_if_gap: got %0d want 16", i - last_i); end
            end
            last_i = i;
         end
      end
      n_vec++; if (nm != 5) begin n_err++; $display("FAIL periodic_match_count: got %0d want 5", nm); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
         if (a !== e) begin n_err++; $display("FAIL periodic_sb: {tmr,match,if} got %h want %h", a, e); end
      end
   endtask

   task automatic test_scaled();
      logic [9:0] e, a;
      int last_m = -1, last_i = -1, nm = 0, ni = 0;
      cyc(1'b1, A_T2CON, 8'h00);
      cyc(1'b1, A_PR2, 8'h01);
      cyc(1'b1, A_TMR2, 8'h00);
      cyc(1'b1, A_T2CON, 8'hA5);
      periph_addr = A_T2CON; #1;
      n_vec++; if (periph_data_out !== 8'h25) begin n_err++; $display("FAIL t2con_readback: got %h want 25", periph_data_out); end
      periph_addr = A_PR2; #1;
      n_vec++; if (periph_data_out !== 8'h01) begin n_err++; $display("FAIL pr2_readback: got %h want 01", periph_data_out); end
      for (int i = 0; i < 340; i++) begin
         cyc(1'b0, A_TMR2, 8'h00);
         a = act_q[$];
         if (a[1]) begin
            if (last_m >= 0) begin
               n_vec++; if (i - last_m != 32) begin n_err++; $display("FAIL scaled_match_gap: got %0d want 32", i - last_m); end
            end
            last_m = i; nm++;
         end
         if (a[0]) begin
            if (last_i >= 0) begin
               n_vec++; if (i - last_i != 160) begin n_err++; $display("FAIL scaled_if_gap: got %0d want 160", i - last_i); end
            end
            last_i = i; ni++;
         end
      end
      n_vec++; if (nm != 10) begin n_err++; $display("FAIL scaled_match_count: got %0d want 10", nm); end
      n_vec++; if (ni != 2) begin n_err++; $display("FAIL scaled_if_count: got %0d want 2", ni); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
         if (a !== e) begin n_err++; $display("FAIL scaled_sb: {tmr,match,if} got %h want %h", a, e); end
      end
   endtask

   task automatic test_wrap();
      logic [9:0] e, a;
      logic [7:0] prev = 8'hF0;
      logic [7:0] prev_at_match = 8'h00;
      bit   saw_zero = 0;
      int   nm = 0;
      cyc(1'b1, A_T2CON, 8'h00);
      cyc(1'b1, A_PR2, 8'h10);
      cyc(1'b1, A_TMR2, 8'hF0);
      cyc(1'b1, A_T2CON, 8'h04);
      for (int i = 0; i < 136; i++) begin
         cyc(1'b0, A_TMR2, 8'h00);
         a = act_q[$];
         if (a[1]) begin
            if (nm == 0) prev_at_match = prev;
            nm++;
         end else if (nm == 0 && a[9:2] == 8'h00) begin
            saw_zero = 1;
         end
         prev = a[9:2];
      end
      n_vec++; if (nm != 1) begin n_err++; $display("FAIL wrap_match_count: got %0d want 1", nm); end
      n_vec++; if (!saw_zero) begin n_err++; $display("FAIL wrap_no_match_at_ff: got no silent wrap want wrap to 00"); end
      n_vec++; if (prev_at_match !== 8'h10) begin n_err++; $display("FAIL wrap_match_value: got %h want 10", prev_at_match); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
         if (a !== e) begin n_err++; $display("FAIL wrap_sb: {tmr,match,if} got %h want %h", a, e); end
      end
   endtask

   task automatic test_collision();
      logic [9:0] e, a;
      int k = 0;
      cyc(1'b1, A_T2CON, 8'h00);
      cyc(1'b1, A_PR2, 8'h05);
      cyc(1'b1, A_TMR2, 8'h05);
      cyc(1'b1, A_T2CON, 8'h05);
      while (k < 80 && !(ph == 1 && m_pre == 3 && m_tmr == m_pr2)) begin
         cyc(1'b0, A_TMR2, 8'h00); k++;
      end
      if (!(ph == 1 && m_pre == 3 && m_tmr == m_pr2)) begin
         n_vec++; n_err++; $display("FAIL collision_setup: got timeout want matching tick");
      end
      cyc(1'b1, A_TMR2, 8'h42);
      a = act_q[$];
      n_vec++; if (a !== {8'h42, 2'b00}) begin n_err++; $display("FAIL collision_write: got %h want %h", a, {8'h42, 2'b00}); end
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, A_TMR2, 8'h00);
         a = act_q[$];
         if (i == 15) begin
            n_vec++; if (a[9:2] !== 8'h42) begin n_err++; $display("FAIL collision_prescale_hold: got %h want 42", a[9:2]); end
         end
      end
      a = act_q[$];
      n_vec++; if (a[9:2] !== 8'h43) begin n_err++; $display("FAIL collision_prescale_restart: got %h want 43", a[9:2]); end
      // PR2 write on a matching tick: the old PR2 still decides the match.
      cyc(1'b1, A_T2CON, 8'h04);
      cyc(1'b1, A_TMR2, 8'h03);
      k = 0;
      while (k < 80 && !(ph == 1 && m_tmr == m_pr2)) begin
         cyc(1'b0, A_TMR2, 8'h00); k++;
      end
      if (!(ph == 1 && m_tmr == m_pr2)) begin
         n_vec++; n_err++; $display("FAIL pr2_tick_setup: got timeout want matching tick");
      end
      cyc(1'b1, A_PR2, 8'h80);
      a = act_q[$];
      n_vec++; if (a[9:1] !== {8'h00, 1'b1}) begin n_err++; $display("FAIL pr2_tick_old_pr2: got %h want %h", a[9:1], {8'h00, 1'b1}); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
         if (a !== e) begin n_err++; $display("FAIL collision_sb: {tmr,match,if} got %h want %h", a, e); end
      end
   endtask

   task automatic test_reset_mid();
      logic [9:0] e, a;
      int  k = 0;
      bit  saw_7a = 0;
      cyc(1'b1, A_T2CON, 8'h00);
      cyc(1'b1, A_PR2, 8'h7A);
      cyc(1'b1, A_TMR2, 8'h78);
      cyc(1'b1, A_T2CON, 8'h04);
      while (k < 64 && !m_match) begin
         cyc(1'b0, A_TMR2, 8'h00);
         if (act_q[$][9:2] == 8'h7A) saw_7a = 1;
         k++;
      end
      n_vec++; if (!(m_match && saw_7a)) begin n_err++; $display("FAIL resetmid_setup: got match=%b saw7A=%b want 1 1", m_match, saw_7a); end
      #1 rst = 1'b1;
      #1;
      n_vec++; if ({tmr2_match, tmr2if_set_en} !== 2'b00) begin n_err++; $display("FAIL resetmid_pulse_drop: got %b want 00", {tmr2_match, tmr2if_set_en}); end
      n_vec++; if (periph_data_out !== 8'h00) begin n_err++; $display("FAIL resetmid_tmr2: got %h want 00", periph_data_out); end
      periph_addr = A_T2CON; #1;
      n_vec++; if (periph_data_out !== 8'h00) begin n_err++; $display("FAIL resetmid_t2con: got %h want 00", periph_data_out); end
      periph_addr = A_PR2; #1;
      n_vec++; if (periph_data_out !== 8'hFF) begin n_err++; $display("FAIL resetmid_pr2: got %h want FF", periph_data_out); end
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (40) cyc(1'b0, A_TMR2, 8'h00);
      n_vec++; if (act_q[$][9:2] !== 8'h00) begin n_err++; $display("FAIL resetmid_stays_off: got %h want 00", act_q[$][9:2]); end
      cyc(1'b1, A_T2CON, 8'h04);
      repeat (12) cyc(1'b0, A_TMR2, 8'h00);
      n_vec++; if (act_q[$][9:2] !== 8'h03) begin n_err++; $display("FAIL resetmid_resume: got %h want 03", act_q[$][9:2]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front(); n_vec++;
         if (a !== e) begin n_err++; $display("FAIL resetmid_sb: {tmr,match,if} got %h want %h", a, e); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_periodic();
      test_scaled();
      test_wrap();
      test_collision();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
